// File: rtl/palette_output_engine_pkg.sv
// Shared types and defaults for the palette output engine.
//   RGBcolor    : 4-bit-per-channel colour as driven to the DAC pins
//   screenXY    : x/y coordinate pair presented to the framebuffer
//   fill_mode_t : how transparent (index 0) pixels are filled
//   DEF_*       : standard 640x480 timing, used as parameter defaults
package palette_output_engine_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } RGBcolor;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } screenXY;

  typedef enum logic [1:0] {
    FILL_NONE   = 2'd0,
    FILL_COLUMN = 2'd1,
    FILL_ROW    = 2'd2
  } fill_mode_t;

  // The reserved encoding 3 falls back to no fill.
  function automatic fill_mode_t decode_fill_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return FILL_COLUMN;
      2'd2:    return FILL_ROW;
      default: return FILL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/palette_output_engine_if.sv
// Bus bundle between the scan-out engine and its surroundings.
//   pal_we/pal_addr/pal_data : palette write port
//   framebuffer_coords       : coordinates requested from the framebuffer
//   framebuffer_output       : palette index returned by the framebuffer
//   hs/vs/new_frame/color_out: video outputs towards the DAC
// master = the engine, slave = framebuffer/CPU/DAC side.
interface palette_output_engine_if #(parameter int IDX_W = 3);
  import palette_output_engine_pkg::*;

  logic             pal_we;
  logic [IDX_W-1:0] pal_addr;
  RGBcolor          pal_data;
  screenXY          framebuffer_coords;
  logic [IDX_W-1:0] framebuffer_output;
  logic             hs;
  logic             vs;
  logic             new_frame;
  RGBcolor          color_out;

  modport master (
    input  pal_we, pal_addr, pal_data, framebuffer_output,
    output framebuffer_coords, hs, vs, new_frame, color_out
  );

  modport slave (
    output pal_we, pal_addr, pal_data, framebuffer_output,
    input  framebuffer_coords, hs, vs, new_frame, color_out
  );

endinterface

// File: rtl/palette_output_engine_timing.sv
// vga_timing_gen: horizontal/vertical counters and the undelayed sync,
// active and vertical-blank flags derived from them.
//   Clk, Reset         : pixel clock, synchronous active-high reset
//   hc, vc             : current counter values
//   hsync_raw/vsync_raw: active-low sync before any alignment delay
//   active_raw         : inside the visible area
//   vblank_raw         : on a line below the visible area
module vga_timing_gen import palette_output_engine_pkg::*; #(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic [COORD_W-1:0] hc,
  output logic [COORD_W-1:0] vc,
  output logic               hsync_raw,
  output logic               vsync_raw,
  output logic               active_raw,
  output logic               vblank_raw
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [COORD_W-1:0] hc_q, hc_d;
  logic [COORD_W-1:0] vc_q, vc_d;

  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc         = hc_q;
  assign vc         = vc_q;
  assign hsync_raw  = !((hc_q >= HS_START) && (hc_q < HS_END));
  assign vsync_raw  = !((vc_q >= VS_START) && (vc_q < VS_END));
  assign active_raw = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign vblank_raw = (vc_q >= V_VIS);

endmodule

// File: rtl/palette_output_engine.sv
// VGA scan-out stage: generates timing, requests framebuffer pixels at
// downscaled coordinates, fills transparent pixels according to the
// per-frame fill mode and resolves indices through a writable palette.
//   Clk, Reset : pixel clock, synchronous active-high reset
//   fill_mode  : 0 none, 1 column hold, 2 row hold, 3 = none
//   bus        : palette write port, framebuffer request/return and
//                hs/vs/new_frame/color_out (all FB_LATENCY+1 behind hc/vc)
module palette_output_engine import palette_output_engine_pkg::*; #(
  parameter int H_VISIBLE   = DEF_H_VISIBLE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_VISIBLE   = DEF_V_VISIBLE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int SCALE_SHIFT = 1,
  parameter int IDX_W       = 3,
  parameter int FB_LATENCY  = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [1:0]              fill_mode,
  palette_output_engine_if.master bus
);

  localparam int COLS   = H_VISIBLE >> SCALE_SHIFT;
  localparam int COL_AW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NPAL   = 1 << IDX_W;
  localparam logic [COORD_W-1:0] COLS_LIM = COORD_W'(COLS);

  typedef struct packed {
    logic               hsync;
    logic               vsync;
    logic               active;
    logic               vblank;
    logic [COORD_W-1:0] x;
  } align_t;

  localparam align_t ALIGN_BLANK = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0,
                                     vblank: 1'b0, x: '0};

  logic [COORD_W-1:0] hc, vc, coord_x, coord_y;
  logic               hsync_raw, vsync_raw, active_raw, vblank_raw;

  vga_timing_gen #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .Clk       (Clk),
    .Reset     (Reset),
    .hc        (hc),
    .vc        (vc),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .active_raw(active_raw),
    .vblank_raw(vblank_raw)
  );

  assign coord_x = hc >> SCALE_SHIFT;
  assign coord_y = vc >> SCALE_SHIFT;
  assign bus.framebuffer_coords = screenXY'{x: coord_x, y: coord_y};

  // Timing info travels alongside the framebuffer read so that the last
  // stage sees the flags belonging to the index arriving this cycle.
  align_t align_d [FB_LATENCY];
  align_t align_q [FB_LATENCY];
  align_t stage;

  always_comb begin
    align_d[0] = '{hsync: hsync_raw, vsync: vsync_raw, active: active_raw,
                   vblank: vblank_raw, x: coord_x};
    for (int i = 1; i < FB_LATENCY; i++) align_d[i] = align_q[i-1];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < FB_LATENCY; i++) align_q[i] <= ALIGN_BLANK;
    end else begin
      align_q <= align_d;
    end
  end

  assign stage = align_q[FB_LATENCY-1];

  RGBcolor          palette_q  [NPAL];
  logic [IDX_W-1:0] col_hold_q [COLS];
  logic [IDX_W-1:0] row_hold_q, row_hold_d;
  fill_mode_t       mode_q, mode_d;
  logic             hs_q, hs_d, vs_q, vs_d, new_frame_q, new_frame_d;
  RGBcolor          color_q, color_d;

  logic [IDX_W-1:0]  fb_idx, idx_out, col_rd, col_wdata;
  logic [COL_AW-1:0] x_idx;
  logic              x_in, col_we;

  assign fb_idx = bus.framebuffer_output;
  assign x_in   = stage.x < COLS_LIM;
  assign x_idx  = stage.x[COL_AW-1:0];
  assign col_rd = col_hold_q[x_idx];

  // Outside the active area the row hold is cleared (so every line starts
  // empty) and, on vertical-blank lines, the sweeping x wipes one column
  // hold entry per cycle so the array is clean before line 0.
  always_comb begin
    idx_out    = '0;
    col_we     = 1'b0;
    col_wdata  = '0;
    row_hold_d = row_hold_q;
    if (stage.active) begin
      if (fb_idx != '0) begin
        idx_out    = fb_idx;
        col_we     = x_in;
        col_wdata  = fb_idx;
        row_hold_d = fb_idx;
      end else begin
        case (mode_q)
          FILL_COLUMN: idx_out = x_in ? col_rd : '0;
          FILL_ROW:    idx_out = row_hold_q;
          default:     idx_out = '0;
        endcase
      end
    end else begin
      row_hold_d = '0;
      col_we     = stage.vblank && x_in;
    end
    color_d     = stage.active ? palette_q[idx_out] : '0;
    hs_d        = stage.hsync;
    vs_d        = stage.vsync;
    new_frame_d = vs_q && !stage.vsync;
    mode_d      = new_frame_q ? decode_fill_mode(fill_mode) : mode_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      new_frame_q <= 1'b0;
      color_q     <= '0;
      row_hold_q  <= '0;
      mode_q      <= FILL_NONE;
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      new_frame_q <= new_frame_d;
      color_q     <= color_d;
      row_hold_q  <= row_hold_d;
      mode_q      <= mode_d;
    end
  end

  // The lookup above reads the pre-write contents, so a write to the entry
  // being displayed only shows from the following cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NPAL; i++) palette_q[i] <= '0;
    end else if (bus.pal_we) begin
      palette_q[bus.pal_addr] <= bus.pal_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < COLS; i++) col_hold_q[i] <= '0;
    end else if (col_we) begin
      col_hold_q[x_idx] <= col_wdata;
    end
  end

  assign bus.hs        = hs_q;
  assign bus.vs        = vs_q;
  assign bus.new_frame = new_frame_q;
  assign bus.color_out = color_q;

endmodule

// File: tb/tb_palette_output_engine.sv
// Directed bench for palette_output_engine using a reduced 48x31 raster
// (32x24 visible) so several frames fit in a short run. A second instance
// with SCALE_SHIFT=2 / FB_LATENCY=3 runs on the same clock and reset.
module tb_palette_output_engine;
  import palette_output_engine_pkg::*;

  localparam int HV = 32, HF = 4, HSW = 8, HB = 4;
  localparam int VV = 24, VF = 2, VSW = 2, VB = 3;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT_M = 1;
  localparam int LAT_V = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] fill_mode = 2'd0;
  logic [1:0] fill_mode_v = 2'd0;
  int         fb_pattern = 0;
  int         total = 0;
  int         bad = 0;
  int         hc_m = 0;
  int         vc_m = 0;

  always #5 Clk = ~Clk;

  palette_output_engine_if #(.IDX_W(3)) bus_m ();
  palette_output_engine_if #(.IDX_W(3)) bus_v ();

  palette_output_engine #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SCALE_SHIFT(1), .IDX_W(3), .FB_LATENCY(LAT_M)
  ) dut_m (
    .Clk(Clk), .Reset(Reset), .fill_mode(fill_mode), .bus(bus_m)
  );

  palette_output_engine #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SCALE_SHIFT(2), .IDX_W(3), .FB_LATENCY(LAT_V)
  ) dut_v (
    .Clk(Clk), .Reset(Reset), .fill_mode(fill_mode_v), .bus(bus_v)
  );

  // Framebuffer models: registered read paths of the required latency.
  screenXY sh_m = '0;
  screenXY sh_v [LAT_V] = '{default: '0};

  function automatic logic [2:0] fb_index(input int pat, input int x, input int y);
    case (pat)
      1:       return (x == 10 && y == 10) ? 3'd5 : 3'd0;
      2:       return (x == 7 && y == 4) ? 3'd3 : 3'd0;
      3:       return (x == 2 && y == 9) ? 3'd6 : 3'd0;
      4:       return (x == 5 && y == 3) ? 3'd2 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  always @(posedge Clk) begin
    sh_m     <= bus_m.framebuffer_coords;
    sh_v[0]  <= bus_v.framebuffer_coords;
    sh_v[1]  <= sh_v[0];
    sh_v[2]  <= sh_v[1];
  end

  assign bus_m.framebuffer_output = fb_index(fb_pattern, int'(sh_m.x), int'(sh_m.y));
  assign bus_v.framebuffer_output = (sh_v[LAT_V-1].x == 10'd5) ? 3'd1 : 3'd0;

  // Reference raster position: what hc/vc should be in the current cycle.
  always @(posedge Clk) begin
    if (Reset) begin
      hc_m <= 0;
      vc_m <= 0;
    end else if (hc_m == HT - 1) begin
      hc_m <= 0;
      vc_m <= (vc_m == VT - 1) ? 0 : vc_m + 1;
    end else begin
      hc_m <= hc_m + 1;
    end
  end

  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic waitPos(input int h, input int v);
    bit hit = 1'b0;
    for (int n = 0; n < 2 * FRAME && !hit; n++) begin
      @(negedge Clk);
      hit = (hc_m == h) && (vc_m == v);
    end
    if (!hit) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_pos(%0d,%0d) got=timeout exp=reached", h, v);
    end
  endtask

  task automatic waitNewFrame();
    bit hit = 1'b0;
    for (int n = 0; n < 2 * FRAME && !hit; n++) begin
      @(negedge Clk);
      hit = bus_m.new_frame;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_new_frame got=timeout exp=pulse");
    end
  endtask

  task automatic applyStimulus(input int pat, input logic [1:0] mode);
    fb_pattern = pat;
    fill_mode  = mode;
    waitNewFrame();
  endtask

  task automatic palWrite(input bit variant, input logic [2:0] addr, input logic [11:0] data);
    if (variant) begin
      bus_v.pal_we = 1'b1; bus_v.pal_addr = addr; bus_v.pal_data = data;
    end else begin
      bus_m.pal_we = 1'b1; bus_m.pal_addr = addr; bus_m.pal_data = data;
    end
    @(negedge Clk);
    bus_m.pal_we = 1'b0;
    bus_v.pal_we = 1'b0;
  endtask

  typedef struct {
    int          scen;
    int          pat;
    logic [1:0]  mode;
    int          px;
    int          py;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int hs_lo = 0, vs_lo = 0, nf = 0, nf_h = -1, nf_v = -1, hs_first = -1;
    int cur = -1;
    int n;

    bus_m.pal_we = 1'b0; bus_m.pal_addr = '0; bus_m.pal_data = '0;
    bus_v.pal_we = 1'b0; bus_v.pal_addr = '0; bus_v.pal_data = '0;

    // scen 1: single red pixel, no fill
    vecs.push_back('{1, 1, 2'd0, 35,  5, 12'h000});
    vecs.push_back('{1, 1, 2'd0, 19, 20, 12'h000});
    vecs.push_back('{1, 1, 2'd0, 20, 20, 12'hF00});
    vecs.push_back('{1, 1, 2'd0, 21, 20, 12'hF00});
    vecs.push_back('{1, 1, 2'd0, 22, 20, 12'h000});
    vecs.push_back('{1, 1, 2'd0, 21, 21, 12'hF00});
    vecs.push_back('{1, 1, 2'd0, 20, 22, 12'h000});
    // scen 2: column hold from fb (7,4)
    vecs.push_back('{2, 2, 2'd1, 14,  7, 12'h000});
    vecs.push_back('{2, 2, 2'd1, 14,  8, 12'h0F0});
    vecs.push_back('{2, 2, 2'd1, 15,  9, 12'h0F0});
    vecs.push_back('{2, 2, 2'd1, 13, 15, 12'h000});
    vecs.push_back('{2, 2, 2'd1, 14, 15, 12'h0F0});
    vecs.push_back('{2, 2, 2'd1, 16, 15, 12'h000});
    vecs.push_back('{2, 2, 2'd1,  2, 20, 12'h000});
    vecs.push_back('{2, 2, 2'd1, 15, 23, 12'h0F0});
    // scen 3: column hold does not survive into an all-zero frame
    vecs.push_back('{3, 0, 2'd1, 14, 15, 12'h000});
    vecs.push_back('{3, 0, 2'd1, 15, 20, 12'h000});
    // scen 4: row hold from fb (2,9)
    vecs.push_back('{4, 3, 2'd2,  3, 18, 12'h000});
    vecs.push_back('{4, 3, 2'd2,  4, 18, 12'h00F});
    vecs.push_back('{4, 3, 2'd2, 30, 18, 12'h00F});
    vecs.push_back('{4, 3, 2'd2,  3, 19, 12'h000});
    vecs.push_back('{4, 3, 2'd2, 31, 19, 12'h00F});
    vecs.push_back('{4, 3, 2'd2, 10, 20, 12'h000});
    vecs.push_back('{4, 3, 2'd2,  4, 21, 12'h000});

    // Reset state
    repeat (3) @(negedge Clk);
    checkOutput("reset_hs", 32'(bus_m.hs), 32'd1);
    checkOutput("reset_vs", 32'(bus_m.vs), 32'd1);
    checkOutput("reset_new_frame", 32'(bus_m.new_frame), 32'd0);
    checkOutput("reset_color", 32'(bus_m.color_out), 32'd0);
    checkOutput("reset_coords", 32'(bus_m.framebuffer_coords), 32'd0);
    Reset = 1'b0;

    // One full frame of sync statistics
    for (int k = 0; k < FRAME; k++) begin
      @(negedge Clk);
      if (!bus_m.hs) hs_lo++;
      if (!bus_m.vs) vs_lo++;
      if (bus_m.new_frame) begin
        nf++; nf_h = hc_m; nf_v = vc_m;
      end
      if (vc_m == 0 && !bus_m.hs && hs_first < 0) hs_first = hc_m;
    end
    checkOutput("hs_low_cycles", 32'(hs_lo), 32'(VT * HSW));
    checkOutput("vs_low_cycles", 32'(vs_lo), 32'(VSW * HT));
    checkOutput("new_frame_count", 32'(nf), 32'd1);
    checkOutput("new_frame_hc", 32'(nf_h), 32'(LAT_M + 1));
    checkOutput("new_frame_vc", 32'(nf_v), 32'(VV + VF));
    checkOutput("hs_first_low_hc", 32'(hs_first), 32'(HV + HF + LAT_M + 1));

    palWrite(1'b0, 3'd5, 12'hF00);
    palWrite(1'b0, 3'd3, 12'h0F0);
    palWrite(1'b0, 3'd6, 12'h00F);
    palWrite(1'b0, 3'd2, 12'hABC);
    palWrite(1'b1, 3'd1, 12'h0F0);

    foreach (vecs[i]) begin
      if (vecs[i].scen != cur) begin
        cur = vecs[i].scen;
        applyStimulus(vecs[i].pat, vecs[i].mode);
      end
      waitPos(vecs[i].px + LAT_M + 1, vecs[i].py);
      checkOutput($sformatf("pix_s%0d_%0d_%0d", vecs[i].scen, vecs[i].px, vecs[i].py),
                  32'(bus_m.color_out), 32'(vecs[i].exp));
    end

    // Variant instance alignment and palette write collision
    applyStimulus(4, 2'd0);
    waitPos(23, 3); checkOutput("var_px19", 32'(bus_v.color_out), 32'h000);
    waitPos(24, 3); checkOutput("var_px20", 32'(bus_v.color_out), 32'h0F0);
    waitPos(27, 3);
    checkOutput("var_px23", 32'(bus_v.color_out), 32'h0F0);
    checkOutput("var_coords", 32'(bus_v.framebuffer_coords), 32'({10'd6, 10'd0}));
    checkOutput("main_coords", 32'(bus_m.framebuffer_coords), 32'({10'd13, 10'd1}));
    waitPos(28, 3); checkOutput("var_px24", 32'(bus_v.color_out), 32'h000);
    waitPos(37, 3); checkOutput("main_hs_before", 32'(bus_m.hs), 32'd1);
    waitPos(38, 3); checkOutput("main_hs_edge", 32'(bus_m.hs), 32'd0);
    waitPos(39, 3); checkOutput("var_hs_before", 32'(bus_v.hs), 32'd1);
    waitPos(40, 3); checkOutput("var_hs_edge", 32'(bus_v.hs), 32'd0);

    waitPos(11, 6);
    bus_m.pal_we = 1'b1; bus_m.pal_addr = 3'd2; bus_m.pal_data = 12'h123;
    @(negedge Clk);
    bus_m.pal_we = 1'b0;
    checkOutput("pal_collision_old", 32'(bus_m.color_out), 32'hABC);
    @(negedge Clk);
    checkOutput("pal_collision_new", 32'(bus_m.color_out), 32'h123);

    // Mode change mid-frame only applies from the next frame
    applyStimulus(2, 2'd0);
    waitPos(0, 2);
    fill_mode = 2'd1;
    waitPos(16, 8);  checkOutput("mid_direct", 32'(bus_m.color_out), 32'h0F0);
    waitPos(16, 15); checkOutput("mid_no_fill", 32'(bus_m.color_out), 32'h000);
    waitNewFrame();
    waitPos(16, 15); checkOutput("next_fill", 32'(bus_m.color_out), 32'h0F0);
    waitPos(18, 15); checkOutput("next_other_col", 32'(bus_m.color_out), 32'h000);

    // Reset in the middle of a frame
    fb_pattern = 1;
    waitPos(10, 5);
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("midreset_coords", 32'(bus_m.framebuffer_coords), 32'd0);
    checkOutput("midreset_hs", 32'(bus_m.hs), 32'd1);
    checkOutput("midreset_color", 32'(bus_m.color_out), 32'd0);
    Reset = 1'b0;
    n = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge Clk);
      n++;
      if (bus_m.new_frame) break;
    end
    checkOutput("midreset_nf_delay", 32'(n), 32'((VV + VF) * HT + LAT_M + 1));
    checkOutput("midreset_nf_vs", 32'(bus_m.vs), 32'd0);
    waitPos(20 + LAT_M + 1, 20);
    checkOutput("midreset_palette_clear", 32'(bus_m.color_out), 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
